// File: rtl/ram_chk_pkg.sv
// ram_chk_pkg
//   Shared types and helpers for the RAM write/read self-test checker.
//   - state_e       : checker FSM states
//   - LFSR_TAPS     : Fibonacci LFSR tap masks for maximal-length sequences, indexed by width (3..8)
//   - lfsr_feedback : feedback bit for a register of the given width
//   - lfsr_next     : full next-state value (8-bit container, upper bits zero)
package ram_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Bit i set means register bit i feeds the XOR. Entries 0..2 are unused placeholders.
    //   3: x^3+x^2+1   4: x^4+x^3+1   5: x^5+x^3+1
    //   6: x^6+x^5+1   7: x^7+x^6+1   8: x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAPS [0:8] = '{
        8'h00, 8'h00, 8'h00, 8'h06, 8'h0C, 8'h14, 8'h30, 8'h60, 8'hB8
    };

    function automatic logic lfsr_feedback(input logic [7:0] value, input logic [3:0] width);
        return ^(value & LFSR_TAPS[width]);
    endfunction

    // Shift left, feedback enters at bit 0; result masked to the register width.
    function automatic logic [7:0] lfsr_next(input logic [7:0] value, input logic [3:0] width);
        logic [7:0] mask;
        mask = 8'hFF >> (4'd8 - width);
        return {value[6:0], lfsr_feedback(value, width)} & mask;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// lfsr_gen
//   Fibonacci LFSR used both to generate write data and to regenerate the
//   expected read data. load has priority over step.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     load       : q <= seed
//     step       : q <= next LFSR value
//     seed       : value loaded on load
//     q          : current LFSR value
module lfsr_gen
    import ram_chk_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (step) begin
            q_d = {q_q[DATA_W-2:0], lfsr_feedback(8'(q_q), 4'(DATA_W))};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ram_wr_rd_checker.sv
// ram_wr_rd_checker
//   Self-test initiator for a single-port RAM. On start it writes every
//   address with LFSR data, reads every address back, compares the returned
//   data against the regenerated LFSR sequence and reports pass/fail.
//   Ports:
//     clk, rst_n      : clock, async active-low reset
//     start, abort    : sweep request (IDLE only) / stop sweep and return to IDLE
//     busy, done      : sweep in progress (WRITE..DRAIN) / 1-cycle end pulse
//     pass            : no mismatches in the last completed sweep
//     err_count       : saturating mismatch count
//     first_err_addr  : address of first mismatch (0 if none)
//     ram_we/addr/din : RAM request outputs
//     ram_dout        : RAM read data, valid RD_LAT cycles after the address
module ram_wr_rd_checker
    import ram_chk_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1,
    parameter int SEED   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [ADDR_W-1:0]  LAST_ADDR  = '1;
    localparam logic [DATA_W-1:0]  SEED_V     = DATA_W'(SEED);
    localparam int                 DRAIN_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LAT - 1);

    generate
        if (SEED <= 0 || SEED >= (1 << DATA_W)) begin : g_bad_seed
            $error("SEED must be nonzero and fit in DATA_W bits");
        end
        if (DATA_W < 3 || DATA_W > 8) begin : g_bad_width
            $error("DATA_W must be in 3..8");
        end
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
            $error("RD_LAT must be in 1..4");
        end
    endgenerate

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ADDR_W:0]     err_q, err_d;
    logic [ADDR_W-1:0]   first_q, first_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;

    // Compare pipeline: expected data and address travel alongside the RAM read latency.
    logic [RD_LAT-1:0]   pv_q, pv_d;
    logic [DATA_W-1:0]   pe_q [RD_LAT];
    logic [DATA_W-1:0]   pe_d [RD_LAT];
    logic [ADDR_W-1:0]   pa_q [RD_LAT];
    logic [ADDR_W-1:0]   pa_d [RD_LAT];

    logic                lfsr_load, lfsr_step;
    logic [DATA_W-1:0]   lfsr_q, lfsr_succ;
    logic                push, clear_pipe, abort_now, mismatch;

    lfsr_gen #(
        .DATA_W (DATA_W)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (SEED_V),
        .q     (lfsr_q)
    );

    // Value the LFSR will hold after the next step; drives registered ram_din during WRITE.
    assign lfsr_succ = {lfsr_q[DATA_W-2:0], lfsr_feedback(8'(lfsr_q), 4'(DATA_W))};

    assign abort_now = abort && (state_q == ST_WRITE || state_q == ST_READ || state_q == ST_DRAIN);
    assign mismatch  = pv_q[RD_LAT-1] && (ram_dout != pe_q[RD_LAT-1]);

    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign pv_d[gi] = push;
                assign pe_d[gi] = lfsr_q;
                assign pa_d[gi] = addr_q;
            end else begin : g_tail
                assign pv_d[gi] = pv_q[gi-1] && !clear_pipe;
                assign pe_d[gi] = pe_q[gi-1];
                assign pa_d[gi] = pa_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        din_d      = '0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_d      = err_q;
        first_d    = first_q;
        drain_d    = drain_q;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        push       = 1'b0;
        clear_pipe = 1'b0;

        // Retire the oldest compare. err_q==0 doubles as "no mismatch captured yet"
        // because the saturating count never returns to zero within a sweep.
        if (mismatch && !abort_now) begin
            if (err_q != '1) begin
                err_d = err_q + 1'b1;
            end
            if (err_q == '0) begin
                first_d = pa_q[RD_LAT-1];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d   = ST_WRITE;
                    addr_d    = '0;
                    we_d      = 1'b1;
                    din_d     = SEED_V;
                    busy_d    = 1'b1;
                    err_d     = '0;
                    first_d   = '0;
                    pass_d    = 1'b0;
                    lfsr_load = 1'b1;
                end
            end
            ST_WRITE: begin
                if (addr_q == LAST_ADDR) begin
                    state_d   = ST_READ;
                    addr_d    = '0;
                    lfsr_load = 1'b1;
                end else begin
                    addr_d    = addr_q + 1'b1;
                    we_d      = 1'b1;
                    din_d     = lfsr_succ;
                    lfsr_step = 1'b1;
                end
            end
            ST_READ: begin
                push      = 1'b1;
                lfsr_step = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (abort_now) begin
            state_d    = ST_IDLE;
            addr_d     = addr_q;
            we_d       = 1'b0;
            din_d      = '0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            pass_d     = pass_q;
            lfsr_load  = 1'b0;
            lfsr_step  = 1'b0;
            push       = 1'b0;
            clear_pipe = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
            drain_q <= '0;
            pv_q    <= '0;
            pe_q    <= '{default: '0};
            pa_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            first_q <= first_d;
            drain_q <= drain_d;
            pv_q    <= pv_d;
            pe_q    <= pe_d;
            pa_q    <= pa_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign ram_we         = we_q;
    assign ram_addr       = addr_q;
    assign ram_din        = din_q;

endmodule

// File: tb/tb_ram_wr_rd_checker.sv
// Bench for ram_wr_rd_checker: two checkers (read latency 1 and 3) each drive
// their own behavioural RAM. Fault modes make the RAM return corrupted data;
// expected error counts come from comparing what the RAM holds with what it
// returns, address by address.
module tb_ram_wr_rd_checker;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;

    always #5 clk = ~clk;

    logic       busy1, done1, pass1, we1;
    logic [4:0] err1;
    logic [3:0] first1, addr1, din1, dout1;
    logic       busy3, done3, pass3, we3;
    logic [4:0] err3;
    logic [3:0] first3, addr3, din3, dout3;

    int fault_mode = 0;   // 0 ideal, 1 flip bit0 at addr 5, 2 always zero

    logic [3:0]       mem1 [N];
    logic [3:0]       mem3 [N];
    logic [3:0]       ah1;
    logic [2:0][3:0]  ah3;
    logic [3:0]       wr1 [N];
    logic [3:0]       wr3 [N];
    logic [3:0]       golden [N];
    bit               have_golden = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [3:0] ram_fault(input logic [3:0] v, input logic [3:0] a, input int mode);
        case (mode)
            1:       return (a == 4'd5) ? (v ^ 4'd1) : v;
            2:       return 4'd0;
            default: return v;
        endcase
    endfunction

    always @(posedge clk) begin
        if (we1) mem1[addr1] <= din1;
        if (we3) mem3[addr3] <= din3;
        ah1 <= addr1;
        ah3 <= {ah3[1:0], addr3};
    end

    assign dout1 = ram_fault(mem1[ah1], ah1, fault_mode);
    assign dout3 = ram_fault(mem3[ah3[2]], ah3[2], fault_mode);

    ram_wr_rd_checker #(.ADDR_W(4), .DATA_W(4), .RD_LAT(1), .SEED(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_addr(first1),
        .ram_we(we1), .ram_addr(addr1), .ram_din(din1), .ram_dout(dout1)
    );

    ram_wr_rd_checker #(.ADDR_W(4), .DATA_W(4), .RD_LAT(3), .SEED(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .first_err_addr(first3),
        .ram_we(we3), .ram_addr(addr3), .ram_din(din3), .ram_dout(dout3)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Expected results: a mismatch is any address whose returned data differs from its contents.
    task automatic check_results(input string name);
        int e1 = 0, e3 = 0, f1 = 0, f3 = 0;
        bit s1 = 1'b0, s3 = 1'b0;
        for (int a = 0; a < N; a++) begin
            if (ram_fault(mem1[a], 4'(a), fault_mode) != mem1[a]) begin
                if (!s1) f1 = a;
                s1 = 1'b1;
                e1++;
            end
            if (ram_fault(mem3[a], 4'(a), fault_mode) != mem3[a]) begin
                if (!s3) f3 = a;
                s3 = 1'b1;
                e3++;
            end
        end
        if (e1 > 31) e1 = 31;
        if (e3 > 31) e3 = 31;
        check_value({name, "_err1"},   err1,   e1);
        check_value({name, "_first1"}, first1, f1);
        check_value({name, "_pass1"},  pass1,  (e1 == 0) ? 1 : 0);
        check_value({name, "_err3"},   err3,   e3);
        check_value({name, "_first3"}, first3, f3);
        check_value({name, "_pass3"},  pass3,  (e3 == 0) ? 1 : 0);
    endtask

    // Write data: nonzero, 15 distinct values then repeat (maximal 4-bit LFSR),
    // identical across both checkers and across sweeps.
    task automatic check_wdata(input string name);
        int zeros = 0, dups = 0, diff13 = 0, diffg = 0;
        for (int i = 0; i < N; i++) begin
            if (wr1[i] == 4'd0) zeros++;
            if (wr1[i] != wr3[i]) diff13++;
            if (have_golden && wr1[i] != golden[i]) diffg++;
            for (int j = 0; j < i && i < 15; j++)
                if (wr1[i] == wr1[j]) dups++;
        end
        check_value({name, "_wzero"}, zeros, 0);
        check_value({name, "_wdistinct"}, dups, 0);
        check_value({name, "_wperiod"}, wr1[15], wr1[0]);
        check_value({name, "_w13"}, diff13, 0);
        if (have_golden) check_value({name, "_wrepeat"}, diffg, 0);
        else begin
            for (int i = 0; i < N; i++) golden[i] = wr1[i];
            have_golden = 1'b1;
        end
    endtask

    task automatic run_sweep(input int fault, input bit repulse, input string name);
        int done1_at = -1, done3_at = -1, ndone1 = 0, ndone3 = 0;
        int bad1 = 0, bad3 = 0, e3_c20 = 0, e3_c21 = 0;
        fault_mode = fault;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            start = (repulse && (c == 5 || c == 20)) ? 1'b1 : 1'b0;
            if (c <= 16) begin
                if (!(we1 && busy1 && int'(addr1) == c - 1)) bad1++;
                if (!(we3 && busy3 && int'(addr3) == c - 1)) bad3++;
                wr1[c-1] = din1;
                wr3[c-1] = din3;
            end else if (c <= 32) begin
                if (we1 || !busy1 || din1 != 4'd0 || int'(addr1) != c - 17) bad1++;
                if (we3 || !busy3 || din3 != 4'd0 || int'(addr3) != c - 17) bad3++;
            end else if (c == 33) begin
                if (we1 || !busy1 || addr1 != 4'd15) bad1++;
                if (we3 || !busy3 || addr3 != 4'd15) bad3++;
            end
            if (c == 35 && busy1) bad1++;
            if (c == 37 && busy3) bad3++;
            if (c == 1) check_value({name, "_passclr"}, pass1, 0);
            if (c == 20) e3_c20 = int'(err3);
            if (c == 21) e3_c21 = int'(err3);
            if (done1) begin ndone1++; if (done1_at < 0) done1_at = c; end
            if (done3) begin ndone3++; if (done3_at < 0) done3_at = c; end
        end
        check_value({name, "_seq1"}, bad1, 0);
        check_value({name, "_seq3"}, bad3, 0);
        check_value({name, "_done1_at"}, done1_at, 34);
        check_value({name, "_done1_n"}, ndone1, 1);
        check_value({name, "_done3_at"}, done3_at, 36);
        check_value({name, "_done3_n"}, ndone3, 1);
        if (fault == 2) begin
            check_value({name, "_lat3_c20"}, e3_c20, 0);
            check_value({name, "_lat3_c21"}, e3_c21, 1);
        end
        check_wdata(name);
        check_results(name);
        $display("sweep %s: err1=%0d first1=%0d pass1=%0b done1@%0d err3=%0d first3=%0d pass3=%0b done3@%0d",
                 name, err1, first1, pass1, done1_at, err3, first3, pass3, done3_at);
    endtask

    task automatic check_reset_values(input string name);
        check_value({name, "_rst1"}, {busy1, done1, pass1, we1, err1, first1, addr1, din1}, 0);
        check_value({name, "_rst3"}, {busy3, done3, pass3, we3, err3, first3, addr3, din3}, 0);
    endtask

    initial begin
        // Power-on reset
        #2 rst_n = 1'b0;
        #1 check_reset_values("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");

        run_sweep(0, 1'b0, "ideal");
        run_sweep(1, 1'b0, "flip5");
        run_sweep(2, 1'b0, "zero");
        run_sweep(0, 1'b1, "repulse");

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_value("both_busy", {busy1, we1, busy3, we3}, 0);
        $display("start+abort in idle: busy1=%0b busy3=%0b", busy1, busy3);

        // abort mid-write
        begin
            int nd = 0;
            fault_mode = 0;
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            for (int c = 1; c <= 45; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (c == 11) begin
                    check_value("abort_we_busy1", {we1, busy1}, 0);
                    check_value("abort_we_busy3", {we3, busy3}, 0);
                end
                abort = (c == 10) ? 1'b1 : 1'b0;
                if (done1 || done3) nd++;
            end
            check_value("abort_nodone", nd, 0);
            check_value("abort_pass", {pass1, pass3}, 0);
            $display("abort at cycle 10: done pulses=%0d", nd);
        end
        run_sweep(0, 1'b0, "after_abort");

        // reset mid-sweep
        fault_mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        $display("reset asserted at cycle 18");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, 1'b0, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
